// File: rtl/jtag_axi_txn_ctrl_if.sv
// Command/response channel bundle between the JTAG transaction controller
// and the AXI-side async FIFOs. "master" is the controller, "slave" the FIFO side.
interface jtag_axi_txn_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_wr;
  logic [2:0]            cmd_size;
  logic [3:0]            cmd_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_resp;
  logic [3:0]            rsp_tag;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_wr, cmd_size, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_tag
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_wr, cmd_size, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_resp, rsp_tag
  );
endinterface

// File: rtl/jtag_axi_txn_ctrl.sv
// TCK-domain JTAG-to-AXI transaction controller: one txn in flight, one pending slot.
// Optional in-flight timeout enabled by defining JTAG_AXI_TIMEOUT_EN.
module jtag_axi_txn_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  tck,
  input  logic                  trstn,
  input  logic                  req_new_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_wr_i,
  input  logic [2:0]            req_size_i,
  input  logic                  status_rd_i,
  output logic [2:0]            status_state_o,
  output logic [DATA_WIDTH-1:0] status_data_o,
  output logic [1:0]            status_resp_o,
  output logic                  drop_o,
  output logic                  pending_o,
  jtag_axi_txn_ctrl_if.master   bus
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_TOUT} state_e;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                state_q, state_d;
  logic [3:0]            tag_q, tag_d;          // tag for the next command
  logic [3:0]            cur_tag_q, cur_tag_d;  // tag of the txn in flight
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, pend_data_q, pend_data_d;
  logic                  wr_q, wr_d, pend_wr_q, pend_wr_d;
  logic [2:0]            size_q, size_d, pend_size_q, pend_size_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic [1:0]            st_resp_q, st_resp_d;
  logic                  cmd_valid, rsp_ready;

`ifdef JTAG_AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    cur_tag_d   = cur_tag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = wr_q;
    size_d      = size_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_wr_d   = pend_wr_q;
    pend_size_d = pend_size_q;
    pend_vld_d  = pend_vld_q;
    drop_d      = drop_q;
    st_data_d   = st_data_q;
    st_resp_d   = st_resp_q;
    cmd_valid   = 1'b0;
    rsp_ready   = 1'b0;

    if (status_rd_i) drop_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A waiting pending entry issues first; a coincident request refills the slot.
        if (pend_vld_q) begin
          addr_d      = pend_addr_q;
          data_d      = pend_data_q;
          wr_d        = pend_wr_q;
          size_d      = pend_size_q;
          cur_tag_d   = tag_q;
          pend_vld_d  = req_new_i;
          if (req_new_i) begin
            pend_addr_d = req_addr_i;
            pend_data_d = req_data_i;
            pend_wr_d   = req_wr_i;
            pend_size_d = req_size_i;
          end
          state_d = S_ISSUE;
        end else if (req_new_i) begin
          addr_d    = req_addr_i;
          data_d    = req_data_i;
          wr_d      = req_wr_i;
          size_d    = req_size_i;
          cur_tag_d = tag_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (bus.cmd_ready) begin
          tag_d   = tag_q + 4'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rsp_ready = 1'b1;
        if (bus.rsp_valid && (bus.rsp_tag == cur_tag_q)) begin
          st_data_d = bus.rsp_data;
          st_resp_d = bus.rsp_resp;
          state_d   = S_DONE;
        end
      end
      S_DONE, S_TOUT: begin
        if (status_rd_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && req_new_i) begin
      if (!pend_vld_q) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = req_addr_i;
        pend_data_d = req_data_i;
        pend_wr_d   = req_wr_i;
        pend_size_d = req_size_i;
      end else begin
        drop_d = 1'b1;
      end
    end

`ifdef JTAG_AXI_TIMEOUT_EN
    // Abandon the txn; bump the tag even without a handshake so late responses miss.
    cnt_d = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? cnt_q + 1'b1 : '0;
    if (((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
        (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && (state_d != S_DONE)) begin
      if (state_q == S_ISSUE) tag_d = tag_q + 4'd1;
      state_d = S_TOUT;
    end
`endif
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      state_q     <= S_IDLE;
      tag_q       <= '0;
      cur_tag_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      pend_wr_q   <= 1'b0;
      pend_size_q <= '0;
      pend_vld_q  <= 1'b0;
      drop_q      <= 1'b0;
      st_data_q   <= '0;
      st_resp_q   <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      cur_tag_q   <= cur_tag_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_wr_q   <= pend_wr_d;
      pend_size_q <= pend_size_d;
      pend_vld_q  <= pend_vld_d;
      drop_q      <= drop_d;
      st_data_q   <= st_data_d;
      st_resp_q   <= st_resp_d;
    end
  end

`ifdef JTAG_AXI_TIMEOUT_EN
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    status_state_o = 3'd0;
    unique case (state_q)
      S_ISSUE, S_WAIT: status_state_o = 3'd1;
      S_DONE:          status_state_o = (st_resp_q == 2'd0) ? 3'd2 : 3'd3;
      S_TOUT:          status_state_o = 3'd4;
      default:         status_state_o = 3'd0;
    endcase
  end

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_data  = data_q;
  assign bus.cmd_wr    = wr_q;
  assign bus.cmd_size  = size_q;
  assign bus.cmd_tag   = cur_tag_q;
  assign bus.rsp_ready = rsp_ready;
  assign status_data_o = st_data_q;
  assign status_resp_o = st_resp_q;
  assign drop_o        = drop_q;
  assign pending_o     = pend_vld_q;

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Directed self-checking bench for jtag_axi_txn_ctrl; covers the timeout path
// when JTAG_AXI_TIMEOUT_EN is defined.
module tb_jtag_axi_txn_ctrl;
`ifdef JTAG_AXI_TIMEOUT_EN
  localparam int TOUT = 16;
`else
  localparam int TOUT = 4096;
`endif

  logic        tck = 1'b0;
  logic        trstn = 1'b0;
  logic        req_new_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic        req_wr_i = 1'b0;
  logic [2:0]  req_size_i = '0;
  logic        status_rd_i = 1'b0;
  logic [2:0]  status_state_o;
  logic [31:0] status_data_o;
  logic [1:0]  status_resp_o;
  logic        drop_o, pending_o;
  int          checks = 0;
  int          errors = 0;

  jtag_axi_txn_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  jtag_axi_txn_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TOUT)) dut (
    .tck(tck), .trstn(trstn),
    .req_new_i(req_new_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_wr_i(req_wr_i), .req_size_i(req_size_i),
    .status_rd_i(status_rd_i), .status_state_o(status_state_o),
    .status_data_o(status_data_o), .status_resp_o(status_resp_o),
    .drop_o(drop_o), .pending_o(pending_o), .bus(bus.master)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic w);
    req_new_i  = 1'b1;
    req_addr_i = a;
    req_data_i = d;
    req_wr_i   = w;
    req_size_i = 3'd2;
    tick();
    req_new_i  = 1'b0;
  endtask

  task automatic rsp(input logic [3:0] t, input logic [31:0] d, input logic [1:0] r);
    bus.rsp_valid = 1'b1;
    bus.rsp_tag   = t;
    bus.rsp_data  = d;
    bus.rsp_resp  = r;
    tick();
    bus.rsp_valid = 1'b0;
  endtask

  task automatic ack();
    status_rd_i = 1'b1;
    tick();
    status_rd_i = 1'b0;
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_tag   = '0;
    bus.rsp_data  = '0;
    bus.rsp_resp  = '0;
    tick(); tick();
    chk("rst_state", status_state_o, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_rsp_ready", bus.rsp_ready, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_tag", bus.cmd_tag, 0);
    chk("rst_addr", bus.cmd_addr, 0);
    chk("rst_sdata", status_data_o, 0);
    trstn = 1'b1;
    tick();

    // Read, tag 0
    bus.cmd_ready = 1'b1;
    req(32'h1000, 32'h0, 1'b0);
    chk("rd_valid", bus.cmd_valid, 1);
    chk("rd_addr", bus.cmd_addr, 32'h1000);
    chk("rd_wr", bus.cmd_wr, 0);
    chk("rd_tag", bus.cmd_tag, 0);
    chk("rd_run", status_state_o, 1);
    tick();
    chk("rd_wait_ready", bus.rsp_ready, 1);
    chk("rd_wait_valid", bus.cmd_valid, 0);
    rsp(4'd0, 32'hCAFEF00D, 2'd0);
    chk("rd_ok", status_state_o, 2);
    chk("rd_data", status_data_o, 32'hCAFEF00D);
    chk("rd_done_rdy", bus.rsp_ready, 0);
    tick();
    chk("rd_held", status_state_o, 2);
    ack();
    chk("rd_ack", status_state_o, 0);

    // Write with 5 cycles of backpressure, tag 1
    bus.cmd_ready = 1'b0;
    req(32'h2000, 32'h12345678, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.cmd_valid, 1);
      chk("bp_payload", {bus.cmd_addr, bus.cmd_data}, {32'h2000, 32'h12345678});
      chk("bp_wr_tag", {bus.cmd_wr, bus.cmd_tag}, {1'b1, 4'd1});
      tick();
    end
    bus.cmd_ready = 1'b1;
    tick();
    chk("bp_wait", bus.rsp_ready, 1);
    rsp(4'd1, 32'h0, 2'd2);
    chk("wr_err", status_state_o, 3);
    chk("wr_resp", status_resp_o, 2);
    ack();
    chk("wr_ack", status_state_o, 0);

    // Pending and drop: A issues tag 2, B pends, C drops
    req(32'hA000, 32'h0, 1'b0);
    tick();
    req(32'hB000, 32'h0, 1'b0);
    chk("pend_set", pending_o, 1);
    chk("pend_nodrop", drop_o, 0);
    req(32'hC000, 32'h0, 1'b0);
    chk("drop_set", drop_o, 1);
    chk("pend_still", pending_o, 1);
    rsp(4'd2, 32'h11, 2'd0);
    chk("pa_ok", status_state_o, 2);
    ack();
    chk("pa_idle", status_state_o, 0);
    chk("drop_clr", drop_o, 0);
    tick();
    chk("pb_run", status_state_o, 1);
    chk("pb_addr", bus.cmd_addr, 32'hB000);
    chk("pb_tag", bus.cmd_tag, 3);
    chk("pb_pend_clr", pending_o, 0);
    tick();
    rsp(4'd3, 32'h22, 2'd0);
    chk("pb_ok", status_state_o, 2);
    ack();

    // Stale tag: in flight tag 4, tag 7 is popped and ignored
    req(32'hD000, 32'h0, 1'b0);
    tick();
    rsp(4'd7, 32'hDEAD, 2'd0);
    chk("stale_run", status_state_o, 1);
    chk("stale_data", status_data_o, 32'h22);
    rsp(4'd4, 32'h55AA, 2'd0);
    chk("stale_ok", status_state_o, 2);
    chk("stale_good", status_data_o, 32'h55AA);
    ack();

    // Async reset in WAIT
    req(32'hE000, 32'h0, 1'b0);
    tick();
    chk("pre_rst_wait", bus.rsp_ready, 1);
    trstn = 1'b0;
    #1;
    chk("arst_state", status_state_o, 0);
    chk("arst_rdy", bus.rsp_ready, 0);
    chk("arst_addr", bus.cmd_addr, 0);
    chk("arst_sdata", status_data_o, 0);
    tick();
    trstn = 1'b1;
    tick();
    req(32'hF000, 32'h0, 1'b0);
    chk("post_rst_tag", bus.cmd_tag, 0);
    tick();
    rsp(4'd0, 32'h77, 2'd0);
    chk("post_rst_ok", status_state_o, 2);
    ack();

`ifdef JTAG_AXI_TIMEOUT_EN
    // Timeout without handshake (tag 1 never accepted), then tag 2 ignores late tag 1
    bus.cmd_ready = 1'b0;
    req(32'h9000, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("to_run15", status_state_o, 1);
    tick();
    chk("to_state", status_state_o, 4);
    chk("to_valid", bus.cmd_valid, 0);
    ack();
    chk("to_ack", status_state_o, 0);
    bus.cmd_ready = 1'b1;
    req(32'h9100, 32'h0, 1'b0);
    chk("to_next_tag", bus.cmd_tag, 2);
    tick();
    rsp(4'd1, 32'hBAD, 2'd0);
    chk("to_late", status_state_o, 1);
    rsp(4'd2, 32'h600D, 2'd0);
    chk("to_next_ok", status_state_o, 2);
    ack();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
